multi_chan_counter: RTL and testbench

- Parametrised successor to the two-output enable counter: CHANNELS independent WIDTH-bit counters, one addressed per cycle by Slt.
- Each channel has a runtime-programmable enable divisor, a wrap or saturate mode, a sticky overflow flag and a one-cycle terminal tick.
- Reset divisors (ch0 = every enable, ch1 = every 4th enable) reproduce the previous Output0/Output1 behaviour.
- Sits as a self-contained event/statistics counter bank under the top-level datapath.

---
 rtl/multi_chan_counter_pkg.sv | 27 ++
 rtl/multi_chan_counter_channel.sv | 100 ++++++++++
 rtl/multi_chan_counter.sv | 53 +++++
 tb/tb_multi_chan_counter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/multi_chan_counter_pkg.sv
// Shared definitions for the multi-channel event counter bank:
// reset divisor defaults and the per-channel action encoding.
package multi_chan_counter_pkg;

   localparam int DIV_RST_CH0   = 0;
   localparam int DIV_RST_CH1   = 3;
   localparam int DIV_RST_OTHER = 0;

   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_CLR,
      ACT_DIVWR,
      ACT_EN
   } action_t;

   // Reset divisor for a given channel index; ch0 counts every enable,
   // ch1 every fourth, matching the older two-output counter.
   function automatic int reset_div(input int ch);
      if (ch == 0) begin
         return DIV_RST_CH0;
      end else if (ch == 1) begin
         return DIV_RST_CH1;
      end
      return DIV_RST_OTHER;
   endfunction

endpackage

// File: rtl/multi_chan_counter_channel.sv
// One counter channel: prescaled enable, wrap/saturate counter,
// sticky overflow flag and registered one-cycle tick.
module multi_chan_counter_channel
   import multi_chan_counter_pkg::*;
#(
   parameter int                 WIDTH   = 64,
   parameter int                 PRESC_W = 8,
   parameter logic [PRESC_W-1:0] DIV_RST = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sel_hit,
   input  logic               clr,
   input  logic               div_we,
   input  logic [PRESC_W-1:0] div_val,
   input  logic               en,
   input  logic               sat_mode,
   output logic [WIDTH-1:0]   count,
   output logic               tick,
   output logic               ovf
);

   logic [PRESC_W-1:0] pre;
   logic [PRESC_W-1:0] div;

   action_t            act;
   logic [WIDTH-1:0]   count_n;
   logic [PRESC_W-1:0] pre_n;
   logic [PRESC_W-1:0] div_n;
   logic               ovf_n;
   logic               tick_n;

   // Pick the single highest-priority action for this channel, then derive next state
   always_comb begin
      act     = ACT_NONE;
      count_n = count;
      pre_n   = pre;
      div_n   = div;
      ovf_n   = ovf;
      tick_n  = 1'b0;

      if (sel_hit) begin
         if (clr) begin
            act = ACT_CLR;
         end else if (div_we) begin
            act = ACT_DIVWR;
         end else if (en) begin
            act = ACT_EN;
         end
      end

      case (act)
         ACT_CLR: begin
            count_n = '0;
            pre_n   = '0;
            ovf_n   = 1'b0;
         end
         ACT_DIVWR: begin
            div_n = div_val;
            pre_n = '0;
         end
         ACT_EN: begin
            if (pre == div) begin
               pre_n  = '0;
               tick_n = 1'b1;
               if (count != '1) begin
                  count_n = count + WIDTH'(1);
               end else begin
                  ovf_n = 1'b1;
                  if (!sat_mode) begin
                     count_n = '0;
                  end
               end
            end else begin
               pre_n = pre + PRESC_W'(1);
            end
         end
         default: begin
         end
      endcase
   end

   // Channel state register; reset restores this channel's default divisor
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         pre   <= '0;
         div   <= DIV_RST;
         ovf   <= 1'b0;
         tick  <= 1'b0;
      end else begin
         count <= count_n;
         pre   <= pre_n;
         div   <= div_n;
         ovf   <= ovf_n;
         tick  <= tick_n;
      end
   end

endmodule

// File: rtl/multi_chan_counter.sv
// Bank of CHANNELS independent event counters; one channel is addressed
// per cycle by Slt, outputs are flattened per channel.
module multi_chan_counter
   import multi_chan_counter_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 64,
   parameter int PRESC_W  = 8,
   parameter int SEL_W    = $clog2(CHANNELS)
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic                      En,
   input  logic [SEL_W-1:0]          Slt,
   input  logic                      Clr,
   input  logic                      Div_we,
   input  logic [PRESC_W-1:0]        Div_val,
   input  logic                      Sat_mode,
   output logic [CHANNELS*WIDTH-1:0] Count,
   output logic [CHANNELS-1:0]       Tick,
   output logic [CHANNELS-1:0]       Overflow
);

   logic [CHANNELS-1:0] sel_hit;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      logic [WIDTH-1:0] count_w;

      // An out-of-range Slt matches no channel, so the request is dropped
      assign sel_hit[c] = (Slt == SEL_W'(c));

      multi_chan_counter_channel #(
         .WIDTH   (WIDTH),
         .PRESC_W (PRESC_W),
         .DIV_RST (PRESC_W'(reset_div(c)))
      ) u_chan (
         .clk      (Clk),
         .rst_n    (Reset_n),
         .sel_hit  (sel_hit[c]),
         .clr      (Clr),
         .div_we   (Div_we),
         .div_val  (Div_val),
         .en       (En),
         .sat_mode (Sat_mode),
         .count    (count_w),
         .tick     (Tick[c]),
         .ovf      (Overflow[c])
      );

      assign Count[c*WIDTH +: WIDTH] = count_w;
   end

endmodule

// File: tb/tb_multi_chan_counter.sv
// Directed bench for multi_chan_counter: a 4-channel and a 3-channel 8-bit
// build share stimulus; the 3-channel one shows out-of-range selects are ignored.
module tb_multi_chan_counter;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [1:0]  slt;
   logic        clr;
   logic        div_we;
   logic [7:0]  div_val;
   logic        sat_mode;

   logic [31:0] count_a;
   logic [3:0]  tick_a;
   logic [3:0]  ovf_a;
   logic [23:0] count_b;
   logic [2:0]  tick_b;
   logic [2:0]  ovf_b;

   int tests_run = 0;
   int failures  = 0;

   typedef struct {
      logic       en;
      logic [1:0] slt;
      logic       clr;
      logic       div_we;
      logic [7:0] div_val;
      int         chk_ch;
      logic [7:0] exp_count;
      logic [3:0] exp_tick;
      logic [3:0] exp_ovf;
      string      name;
   } vec_t;

   vec_t vecs[$];

   multi_chan_counter #(.CHANNELS(4), .WIDTH(8), .PRESC_W(8)) dut_a (
      .Clk(clk), .Reset_n(rst_n), .En(en), .Slt(slt), .Clr(clr),
      .Div_we(div_we), .Div_val(div_val), .Sat_mode(sat_mode),
      .Count(count_a), .Tick(tick_a), .Overflow(ovf_a)
   );

   multi_chan_counter #(.CHANNELS(3), .WIDTH(8), .PRESC_W(8)) dut_b (
      .Clk(clk), .Reset_n(rst_n), .En(en), .Slt(slt), .Clr(clr),
      .Div_we(div_we), .Div_val(div_val), .Sat_mode(sat_mode),
      .Count(count_b), .Tick(tick_b), .Overflow(ovf_b)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ch_count(input int ch);
      return count_a[ch*8 +: 8];
   endfunction

   function automatic vec_t mk(input logic e, input logic [1:0] s, input logic c,
                               input logic dw, input logic [7:0] dv, input int ch,
                               input logic [7:0] ec, input logic [3:0] et,
                               input string nm);
      vec_t v;
      v.en = e; v.slt = s; v.clr = c; v.div_we = dw; v.div_val = dv;
      v.chk_ch = ch; v.exp_count = ec; v.exp_tick = et; v.exp_ovf = 4'b0000;
      v.name = nm;
      return v;
   endfunction

   task automatic applyStimulus(input logic e, input logic [1:0] s, input logic c,
                                input logic dw, input logic [7:0] dv, input logic sm);
      en = e; slt = s; clr = c; div_we = dw; div_val = dv; sat_mode = sm;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 8'd0, 0);
      applyStimulus(0, 0, 0, 0, 8'd0, 0);
      #2 rst_n = 1'b1;
      #1;
      checkOutput("reset count_a", count_a, 32'd0);
      checkOutput("reset tick_a", 32'(tick_a), 32'd0);
      checkOutput("reset ovf_a", 32'(ovf_a), 32'd0);
      checkOutput("reset count_b", 32'(count_b), 32'd0);

      // ch0: every enable increments
      for (int i = 1; i <= 10; i++)
         vecs.push_back(mk(1, 2'd0, 0, 0, 8'd0, 0, 8'(i), 4'b0001, "ch0 en"));
      // ch1: reset divisor 3, increment on every 4th enable
      for (int j = 1; j <= 8; j++)
         vecs.push_back(mk(1, 2'd1, 0, 0, 8'd0, 1, 8'(j / 4),
                           (j % 4 == 0) ? 4'b0010 : 4'b0000, "ch1 div4"));
      // ch3: divisor write drops simultaneous enable, then 3 enables per increment
      vecs.push_back(mk(1, 2'd3, 0, 1, 8'd2, 3, 8'd0, 4'b0000, "ch3 divwr+en"));
      vecs.push_back(mk(1, 2'd3, 0, 0, 8'd0, 3, 8'd0, 4'b0000, "ch3 en1"));
      vecs.push_back(mk(1, 2'd3, 0, 0, 8'd0, 3, 8'd0, 4'b0000, "ch3 en2"));
      vecs.push_back(mk(1, 2'd3, 0, 0, 8'd0, 3, 8'd1, 4'b1000, "ch3 en3"));
      vecs.push_back(mk(1, 2'd3, 1, 0, 8'd0, 3, 8'd0, 4'b0000, "ch3 clr+en"));
      // interleaved ch0/ch1: ch1 phase survives the switches
      vecs.push_back(mk(1, 2'd1, 0, 0, 8'd0, 1, 8'd2,  4'b0000, "ilv ch1 a"));
      vecs.push_back(mk(1, 2'd0, 0, 0, 8'd0, 0, 8'd11, 4'b0001, "ilv ch0 a"));
      vecs.push_back(mk(1, 2'd1, 0, 0, 8'd0, 1, 8'd2,  4'b0000, "ilv ch1 b"));
      vecs.push_back(mk(1, 2'd0, 0, 0, 8'd0, 0, 8'd12, 4'b0001, "ilv ch0 b"));
      vecs.push_back(mk(1, 2'd1, 0, 0, 8'd0, 1, 8'd2,  4'b0000, "ilv ch1 c"));
      vecs.push_back(mk(1, 2'd1, 0, 0, 8'd0, 1, 8'd3,  4'b0010, "ilv ch1 d"));

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].en, vecs[k].slt, vecs[k].clr, vecs[k].div_we,
                       vecs[k].div_val, 0);
         checkOutput({vecs[k].name, " count"}, 32'(ch_count(vecs[k].chk_ch)),
                     32'(vecs[k].exp_count));
         checkOutput({vecs[k].name, " tick"}, 32'(tick_a), 32'(vecs[k].exp_tick));
         checkOutput({vecs[k].name, " ovf"}, 32'(ovf_a), 32'(vecs[k].exp_ovf));
      end

      // 3-channel build ignored every Slt=3 request
      checkOutput("b counts after slt3", 32'(count_b), 32'h0000030C);
      checkOutput("a ch1 count", 32'(ch_count(1)), 32'd3);

      // ch2 wrap mode
      for (int i = 0; i < 255; i++) applyStimulus(1, 2'd2, 0, 0, 8'd0, 0);
      checkOutput("ch2 at max", 32'(ch_count(2)), 32'd255);
      checkOutput("ch2 no ovf yet", 32'(ovf_a), 32'd0);
      applyStimulus(1, 2'd2, 0, 0, 8'd0, 0);
      checkOutput("ch2 wrap count", 32'(ch_count(2)), 32'd0);
      checkOutput("ch2 wrap ovf", 32'(ovf_a), 32'b0100);
      checkOutput("ch2 wrap tick", 32'(tick_a), 32'b0100);
      checkOutput("b ch2 wrap ovf", 32'(ovf_b), 32'b100);
      applyStimulus(0, 2'd2, 1, 0, 8'd0, 0);
      checkOutput("ch2 clr count", 32'(ch_count(2)), 32'd0);
      checkOutput("ch2 clr ovf", 32'(ovf_a), 32'd0);
      checkOutput("ch2 clr tick", 32'(tick_a), 32'd0);

      // ch1 divisor to 0 so the reset value is observable later
      applyStimulus(0, 2'd1, 0, 1, 8'd0, 0);

      // ch2 saturate mode
      for (int i = 0; i < 255; i++) applyStimulus(1, 2'd2, 0, 0, 8'd0, 1);
      checkOutput("ch2 max again", 32'(ch_count(2)), 32'd255);
      checkOutput("ch2 ovf still clear", 32'(ovf_a), 32'd0);
      applyStimulus(1, 2'd2, 0, 0, 8'd0, 1);
      checkOutput("ch2 sat count", 32'(ch_count(2)), 32'd255);
      checkOutput("ch2 sat ovf", 32'(ovf_a), 32'b0100);
      checkOutput("ch2 sat tick", 32'(tick_a), 32'b0100);
      applyStimulus(1, 2'd2, 0, 0, 8'd0, 1);
      checkOutput("ch2 sat count 2", 32'(ch_count(2)), 32'd255);
      checkOutput("ch2 sat tick 2", 32'(tick_a), 32'b0100);

      // async reset between edges while Tick is high
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async rst count_a", count_a, 32'd0);
      checkOutput("async rst tick_a", 32'(tick_a), 32'd0);
      checkOutput("async rst ovf_a", 32'(ovf_a), 32'd0);
      checkOutput("async rst count_b", 32'(count_b), 32'd0);
      #2 rst_n = 1'b1;

      // ch1 divisor back to 3 after reset
      for (int i = 0; i < 3; i++) applyStimulus(1, 2'd1, 0, 0, 8'd0, 0);
      checkOutput("post rst ch1 3 en", 32'(ch_count(1)), 32'd0);
      applyStimulus(1, 2'd1, 0, 0, 8'd0, 0);
      checkOutput("post rst ch1 4 en", 32'(ch_count(1)), 32'd1);
      checkOutput("post rst ch1 tick", 32'(tick_a), 32'b0010);

      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
